frog_input_ctrl: RTL and testbench

Conditions the four raw, active-low push-button directions into the one-cycle `player_input` move pulses consumed by `update_frog`. Per key it synchronises, debounces, detects the press edge and generates auto-repeat pulses while the key is held. An arbiter then guarantees at most one direction per cycle. It sits between the board KEY pins and `update_frog`, and shares its clock.

---
 rtl/frog_pkg.sv | 24 ++
 rtl/frog_input_ctrl_key_channel.sv | 82 ++++++++
 rtl/frog_input_ctrl.sv | 46 ++++
 tb/tb_frog_input_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/frog_pkg.sv
// Shared direction encoding for the frog move path.
// Bit positions match both the board KEY pins and the update_frog move vector.
package frog_pkg;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;
  localparam int NUM_DIRS  = 4;

  typedef logic [NUM_DIRS-1:0] move_t;

  // Keeps only the highest-priority request: up > down > left > right.
  function automatic move_t pick_highest(input move_t req);
    move_t grant;
    grant = '0;
    if (req[DIR_UP])         grant[DIR_UP]    = 1'b1;
    else if (req[DIR_DOWN])  grant[DIR_DOWN]  = 1'b1;
    else if (req[DIR_LEFT])  grant[DIR_LEFT]  = 1'b1;
    else if (req[DIR_RIGHT]) grant[DIR_RIGHT] = 1'b1;
    return grant;
  endfunction

endpackage

// File: rtl/frog_input_ctrl_key_channel.sv
// One push-button channel: 2-flop synchroniser, debounce, press edge and auto-repeat.
// Emits a registered one-cycle request; gating by enable happens in the arbiter.
module key_channel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic key_n,
  output logic req
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(REPEAT_DELAY);
  // Reloading here puts the next fire exactly REPEAT_PERIOD edges later (needs PERIOD <= DELAY+1).
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             req_q, req_d;
  logic             pressed_s;
  logic             press_edge;
  logic             rpt_fire;

  always_comb begin
    sync1_d    = key_n;
    sync2_d    = sync1_q;
    pressed_s  = ~sync2_q;
    db_d       = db_q;
    db_cnt_d   = '0;
    press_edge = 1'b0;
    if (pressed_s != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d       = pressed_s;
        press_edge = pressed_s;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    rpt_cnt_d = '0;
    rpt_fire  = 1'b0;
    if (db_q && enable) begin
      if (rpt_cnt_q == RPT_FIRE) begin
        rpt_fire  = 1'b1;
        rpt_cnt_d = RPT_RELOAD;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end

    req_d = press_edge | rpt_fire;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      db_q      <= 1'b0;
      db_cnt_q  <= '0;
      rpt_cnt_q <= '0;
      req_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_cnt_q  <= db_cnt_d;
      rpt_cnt_q <= rpt_cnt_d;
      req_q     <= req_d;
    end
  end

  assign req = req_q;

endmodule

// File: rtl/frog_input_ctrl.sv
// Turns the four raw KEY buttons into one-hot-or-zero move pulses for update_frog.
// Per-key conditioning lives in key_channel; this level arbitrates and registers.
module frog_input_ctrl
  import frog_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_DIRS-1:0] key_n,
  output logic [NUM_DIRS-1:0] player_input
);

  move_t req;
  move_t player_input_q, player_input_d;

  for (genvar i = 0; i < NUM_DIRS; i++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_key (
      .clk   (clk),
      .reset (reset),
      .enable(enable),
      .key_n (key_n[i]),
      .req   (req[i])
    );
  end

  // Losing or disabled requests are simply dropped, never queued.
  always_comb begin
    player_input_d = enable ? pick_highest(req) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) player_input_q <= '0;
    else        player_input_q <= player_input_d;
  end

  assign player_input = player_input_q;

endmodule

// File: tb/tb_frog_input_ctrl.sv
// Bench for frog_input_ctrl: directed scenarios with literal expectations plus
// randomized key/enable traffic checked every cycle against a behavioural model.
module tb_frog_input_ctrl;

  localparam int D = 4;
  localparam int R = 8;
  localparam int P = 4;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] key_n;
  logic [3:0] player_input;

  int n_cmp  = 0;
  int n_fail = 0;

  frog_input_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (R),
    .REPEAT_PERIOD  (P)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .key_n       (key_n),
    .player_input(player_input)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: pressed history delayed two edges, a stable-run debounce,
  // and a hold-length count that fires at R+1, R+1+P, R+1+2P ... edges of hold.
  logic [3:0] m_p1, m_p2, m_db, m_req, m_nreq;
  int         m_run [4];
  int         m_hold[4];
  logic [3:0] exp_out;

  function automatic logic [3:0] highest(input logic [3:0] r);
    for (int i = 3; i >= 0; i--)
      if (r[i]) return 4'(1 << i);
    return 4'b0000;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_p1 = '0; m_p2 = '0; m_db = '0; m_req = '0; exp_out = '0;
      for (int k = 0; k < 4; k++) begin
        m_run[k]  = 0;
        m_hold[k] = 0;
      end
    end else begin
      exp_out = enable ? highest(m_req) : 4'b0000;
      for (int k = 0; k < 4; k++) begin
        logic was_held;
        logic edge_press;
        was_held   = m_db[k];
        edge_press = 1'b0;
        if (m_p2[k] != m_db[k]) begin
          m_run[k]++;
          if (m_run[k] == D) begin
            m_db[k]    = m_p2[k];
            m_run[k]   = 0;
            edge_press = m_p2[k];
          end
        end else begin
          m_run[k] = 0;
        end
        if (was_held && enable) m_hold[k]++;
        else                    m_hold[k] = 0;
        m_nreq[k] = edge_press ||
                    (m_hold[k] >= R + 1 && ((m_hold[k] - R - 1) % P) == 0);
        m_p2[k] = m_p1[k];
        m_p1[k] = ~key_n[k];
      end
      m_req = m_nreq;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      n_cmp++;
      if (player_input !== exp_out) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: player_input=%b expected=%b", $time, player_input, exp_out);
      end
    end
  end

  task automatic lit(input string nm, input logic [3:0] exp);
    n_cmp++;
    if (player_input !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: player_input=%b expected=%b", nm, $time, player_input, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    key_n  = 4'b1111;
    enable = 1'b1;
    reset  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    lit("reset_state", 4'b0000);
    reset = 1'b1;

    for (int j = 0; j < 20; j++) begin
      @(posedge clk); @(negedge clk);
      lit("idle", 4'b0000);
    end

    // right key glitch shorter than the debounce window
    @(posedge clk); #2 key_n = 4'b1110;
    for (int j = 0; j < 15; j++) begin
      @(posedge clk); #2;
      if (j == 2) key_n = 4'b1111;
      @(negedge clk);
      lit("glitch", 4'b0000);
    end

    // up held 6 cycles: single press pulse after edge e+6
    @(posedge clk); #2 key_n = 4'b0111;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #2;
      if (j == 5) key_n = 4'b1111;
      @(negedge clk);
      lit("up_single", (j == 6) ? 4'b1000 : 4'b0000);
    end

    // left held 30 cycles: press then repeats
    @(posedge clk); #2 key_n = 4'b1101;
    for (int j = 0; j < 46; j++) begin
      @(posedge clk); #2;
      if (j == 29) key_n = 4'b1111;
      @(negedge clk);
      lit("left_repeat",
          (j == 6 || (j >= 15 && j <= 35 && ((j - 15) % 4) == 0)) ? 4'b0010 : 4'b0000);
    end

    // up and right together: up wins, right repeats appear once up is released
    @(posedge clk); #2 key_n = 4'b0110;
    for (int j = 0; j < 30; j++) begin
      @(posedge clk); #2;
      if (j == 11) key_n = 4'b1110;
      @(negedge clk);
      lit("up_right",
          (j == 6 || j == 15) ? 4'b1000 :
          (j >= 19 && ((j - 19) % 4) == 0) ? 4'b0001 : 4'b0000);
    end
    @(posedge clk); #2 key_n = 4'b1111;
    idle(15);

    // press down while disabled, then enable with it still held
    enable = 1'b0;
    key_n  = 4'b1011;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); @(negedge clk);
      lit("disabled", 4'b0000);
    end
    @(posedge clk); #2 enable = 1'b1;
    for (int j = 0; j < 14; j++) begin
      @(posedge clk); @(negedge clk);
      lit("enable_rise", (j == 9 || j == 13) ? 4'b0100 : 4'b0000);
    end

    // async reset while the output pulse is high, key still held
    #2 reset = 1'b0;
    #1 lit("reset_async", 4'b0000);
    @(posedge clk); #2 reset = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk); @(negedge clk);
      lit("post_reset_press", (j == 6) ? 4'b0100 : 4'b0000);
    end
    @(posedge clk); #2 key_n = 4'b1111;
    idle(15);

    for (int s = 0; s < 60; s++) begin
      @(posedge clk); #2;
      key_n  = 4'($urandom);
      enable = ($urandom_range(0, 7) != 0);
      repeat ($urandom_range(1, 14)) @(posedge clk);
    end
    @(posedge clk); #2;
    key_n  = 4'b1111;
    enable = 1'b1;
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
